// File: rtl/p05_debounce_cell.sv
// Per-bit synchroniser + debouncer producing clean levels and one-cycle rise/fall strobes.
// Optional toggle output (push-button on/off) is enabled with `define P05_DEBOUNCE_TOGGLE_EN.
module p05_debounce_cell #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef P05_DEBOUNCE_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggle
`endif
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // sync_q[0] samples the pin; sync_q[SYNC_STAGES-1] is the settled value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  out_q, out_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [WIDTH-1:0]                  sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_last[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        // Mismatch has persisted long enough: commit the new level.
        out_d[i]  = sync_last[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_last[i];
        fall_d[i] = ~sync_last[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef P05_DEBOUNCE_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q, toggle_d;

  // Flips the cycle after each rise strobe; fall strobes are ignored.
  always_comb begin
    toggle_d = toggle_q ^ rise_q;
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign toggle = toggle_q;
`endif

endmodule
